core_ctrl_fsm: RTL and testbench
================================

# core_ctrl_fsm

Multi-cycle control FSM for the RV32I core: sequences instruction fetch, decode, execute, memory access and register write-back around the shared datapath. It holds the PC and instruction register, and latches the immediate-generator result during decode. It drives the memory request handshakes and computes the next PC for branches and jumps. One instruction is in flight at a time; there is no pipelining.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address, always equal to pc
- imem_ack  in  1  fetch complete, imem_rdata valid
- imem_rdata  in  32  fetched instruction
- inst  out  32  instruction register (feeds decoder and immediate generator)
- imm_val  in  32  combinational immediate from the immediate generator, a function of inst
- imm_q  out  32  immediate latched in DECODE
- pc  out  32  current PC
- link_pc  out  32  pc+4, write-back value for JAL/JALR
- alu_result  in  32  ALU output, valid in EXEC
- br_taken  in  1  branch comparator result, valid in EXEC
- dmem_req  out  1  data memory request
- dmem_we  out  1  store when 1, load when 0; only meaningful with dmem_req
- dmem_ack  in  1  data access complete
- rf_we  out  1  register-file write enable, one-cycle pulse
- wb_sel  out  2  write-back source: 0 ALU, 1 memory, 2 link_pc
- state  out  3  FSM state for debug: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 7 HALT
- illegal  out  1  sticky: unsupported opcode or misaligned target
- bus_err  out  1  sticky memory timeout (see Configuration)

## Operation
- Reset values: state=FETCH, pc=RESET_PC, inst=0, imm_q=0, illegal=0, bus_err=0. All request and enable outputs are 0 during the reset cycle.
- FETCH:
  - imem_req=1.
  - On imem_ack: inst←imem_rdata, go to DECODE.
  - With no ack, stay in FETCH.
- DECODE:
  - imm_q←imm_val.
  - Supported opcodes are 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 1101111 and 1100111. Any supported opcode goes to EXEC.
  - Any other opcode sets illegal and goes to HALT.
- EXEC:
  - One cycle. Next state by opcode class:
    - LOAD or STORE: MEM.
    - BRANCH: FETCH. pc←br_taken ? pc+imm_q : pc+4.
    - All others: WB.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE only.
  - On dmem_ack, LOAD goes to WB.
  - On dmem_ack, STORE goes to FETCH with pc←pc+4.
- WB:
  - rf_we=1 for exactly this cycle, then go to FETCH.
  - wb_sel is 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - PC update:
    - JAL: pc←pc+imm_q.
    - JALR: pc←alu_result & ~32'h1.
    - All others: pc←pc+4.
- Misaligned target: any new PC with bit[1]=1 sets illegal and goes to HALT. In that case pc is not updated, and in WB rf_we is suppressed.
- HALT is absorbing; only rst_n exits it. In HALT all requests and rf_we are 0.
- Arithmetic is 32-bit modulo; pc wraps from 0xFFFF_FFFC to 0 silently.
- An ack arriving while its request is low is ignored.

## Timing
- Minimum instruction latency (ack in the same cycle as req):
  - ALU/LUI/JAL/JALR: 4 cycles.
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each wait cycle on imem_ack or dmem_ack adds one cycle.
- A request stays high, with address and we stable, until the cycle its ack is sampled. It drops in the cycle after the ack.
- rst_n low in any state, including mid-request, returns the FSM to FETCH at the next edge. Requests are low in the cycle following that edge.
- inst and imm_q change only on the FETCH→DECODE and DECODE→EXEC edges respectively.

## Configuration
- CORE_CTRL_TIMEOUT_EN:
  - Defined:
    - An 8-bit counter clears on entry to FETCH or MEM and increments each cycle the request waits.
    - If the count reaches 255 without an ack, bus_err is set and the FSM goes to HALT.
    - An ack in the same cycle as the 255th wait cycle wins.
  - Undefined: the FSM waits indefinitely, bus_err is tied to 0, and no counter is instantiated.

## Test plan
- Reset with RESET_PC=0x100 → after release, imem_req=1 and imem_addr=0x100; pc, imm_q, illegal and bus_err are all 0.
- ADDI 0x00500093 with imm_val=5 and immediate ack → rf_we high in cycle 4, wb_sel=0, pc=0x104 at the next FETCH.
- BEQ 0x00000463, imm_val=8, br_taken=1 → the FETCH after EXEC shows pc=0x108. With br_taken=0, pc=0x104.
- LOAD with dmem_ack delayed 3 cycles → dmem_req high for exactly 4 cycles with dmem_we=0; rf_we pulses once with wb_sel=1; total latency 8 cycles.
- Opcode 0x0000007F, and separately JALR with alu_result=0x202 → illegal=1, state=7, no further imem_req, and no rf_we for the JALR.
- CORE_CTRL_TIMEOUT_EN defined with imem_ack held at 0 → bus_err=1 and state=7 after 255 wait cycles. Reset mid-wait clears bus_err and restarts the fetch at RESET_PC.

Source files
------------

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, write-back around a shared datapath.
// Optional macro CORE_CTRL_TIMEOUT_EN adds an 8-bit bus-wait watchdog that raises bus_err and halts.
module core_ctrl_fsm #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  input  logic [31:0] imm_val,
  output logic [31:0] imm_q,
  output logic [31:0] pc,
  output logic [31:0] link_pc,
  input  logic [31:0] alu_result,
  input  logic        br_taken,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  state_t      st;
  logic [31:0] npc_q;
  logic [6:0]  opcode;
  logic        supported;
  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;
  logic [31:0] exec_tgt;
  logic        is_link;
  logic        tmo;

  assign state     = st;
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign link_pc   = pc_plus4;
  assign opcode    = inst[6:0];
  assign br_tgt    = br_taken ? (pc + imm_q) : pc_plus4;
  assign is_link   = (opcode == OP_JAL) || (opcode == OP_JALR);

  always_comb begin
    supported = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_LUI, OP_JAL, OP_JALR: supported = 1'b1;
      default: supported = 1'b0;
    endcase
  end

  // WB target is resolved in EXEC, where alu_result is guaranteed valid.
  always_comb begin
    exec_tgt = pc_plus4;
    if (opcode == OP_JAL)       exec_tgt = pc + imm_q;
    else if (opcode == OP_JALR) exec_tgt = alu_result & ~32'h1;
  end

`ifdef CORE_CTRL_TIMEOUT_EN
  logic [7:0] wcnt;
  logic       waiting;

  // Wait runs are contiguous within one state, so clearing on any non-wait cycle
  // is the same as clearing on entry to FETCH/MEM.
  assign waiting = ((st == FETCH) && imem_req && !imem_ack) ||
                   ((st == MEM)   && dmem_req && !dmem_ack);
  assign tmo     = (wcnt == 8'd254);

  always_ff @(posedge clk) begin
    if (!rst_n)       wcnt <= '0;
    else if (waiting) wcnt <= wcnt + 8'd1;
    else              wcnt <= '0;
  end
`else
  assign tmo     = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= FETCH;
      pc       <= RESET_PC;
      inst     <= '0;
      imm_q    <= '0;
      npc_q    <= '0;
      illegal  <= 1'b0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      rf_we    <= 1'b0;
      wb_sel   <= 2'd0;
`ifdef CORE_CTRL_TIMEOUT_EN
      bus_err  <= 1'b0;
`endif
    end else begin
      rf_we <= 1'b0;
      case (st)
        FETCH: begin
          if (imem_req && imem_ack) begin
            inst     <= imem_rdata;
            imem_req <= 1'b0;
            st       <= DECODE;
          end else if (imem_req && tmo) begin
`ifdef CORE_CTRL_TIMEOUT_EN
            bus_err  <= 1'b1;
`endif
            imem_req <= 1'b0;
            st       <= HALT;
          end else begin
            imem_req <= 1'b1;
          end
        end
        DECODE: begin
          imm_q <= imm_val;
          if (supported) st <= EXEC;
          else begin
            illegal <= 1'b1;
            st      <= HALT;
          end
        end
        EXEC: begin
          if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
            dmem_req <= 1'b1;
            dmem_we  <= (opcode == OP_STORE);
            st       <= MEM;
          end else if (opcode == OP_BR) begin
            if (br_tgt[1]) begin
              illegal <= 1'b1;
              st      <= HALT;
            end else begin
              pc       <= br_tgt;
              imem_req <= 1'b1;
              st       <= FETCH;
            end
          end else begin
            npc_q  <= exec_tgt;
            rf_we  <= !exec_tgt[1];
            wb_sel <= is_link ? 2'd2 : 2'd0;
            st     <= WB;
          end
        end
        MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (dmem_we) begin
              pc       <= pc_plus4;
              imem_req <= 1'b1;
              st       <= FETCH;
            end else begin
              npc_q  <= pc_plus4;
              rf_we  <= 1'b1;
              wb_sel <= 2'd1;
              st     <= WB;
            end
          end else if (tmo) begin
`ifdef CORE_CTRL_TIMEOUT_EN
            bus_err  <= 1'b1;
`endif
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            st       <= HALT;
          end
        end
        WB: begin
          if (npc_q[1]) begin
            illegal <= 1'b1;
            st      <= HALT;
          end else begin
            pc       <= npc_q;
            imem_req <= 1'b1;
            st       <= FETCH;
          end
        end
        HALT: st <= HALT;
        default: begin
          imem_req <= 1'b0;
          dmem_req <= 1'b0;
          st       <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Directed bench for core_ctrl_fsm: reset, ALU/branch/load/store/jump flows, illegal and timeout cases.
module tb_core_ctrl_fsm;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] imm_val;
  logic [31:0] imm_q;
  logic [31:0] pc;
  logic [31:0] link_pc;
  logic [31:0] alu_result;
  logic        br_taken;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic        illegal;
  logic        bus_err;

  int tests = 0;
  int fails = 0;

  core_ctrl_fsm #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .imm_val(imm_val), .imm_q(imm_q), .pc(pc), .link_pc(link_pc),
    .alu_result(alu_result), .br_taken(br_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .wb_sel(wb_sel), .state(state), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  // Leaves the bench in the first FETCH cycle with imem_req high.
  task automatic do_reset();
    imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic fetch(input logic [31:0] ins, input logic [31:0] imm);
    imem_ack = 1'b1; imem_rdata = ins; imm_val = imm;
    cyc();
    imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    tests++;
    if ({state, imem_req, dmem_req, rf_we, illegal, bus_err} !== 8'b000_00000) begin
      fails++; $display("FAIL reset_ctl: got %b exp 00000000", {state, imem_req, dmem_req, rf_we, illegal, bus_err});
    end
    tests++;
    if ({pc, inst, imm_q} !== {32'h100, 32'h0, 32'h0}) begin
      fails++; $display("FAIL reset_regs: pc=%h inst=%h imm_q=%h exp 100/0/0", pc, inst, imm_q);
    end
    rst_n = 1'b1;
    cyc();
    tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
      fails++; $display("FAIL reset_fetch: req=%b addr=%h exp 1/00000100", imem_req, imem_addr);
    end
  endtask

  task automatic test_addi();
    do_reset();
    fetch(32'h00500093, 32'd5);
    tests++;
    if ({state, imem_req, inst} !== {3'd1, 1'b0, 32'h00500093}) begin
      fails++; $display("FAIL addi_decode: state=%0d req=%b inst=%h exp 1/0/00500093", state, imem_req, inst);
    end
    cyc();
    tests++;
    if ({state, imm_q} !== {3'd2, 32'd5}) begin
      fails++; $display("FAIL addi_exec: state=%0d imm_q=%h exp 2/5", state, imm_q);
    end
    cyc();
    tests++;
    if ({state, rf_we, wb_sel} !== {3'd4, 1'b1, 2'd0}) begin
      fails++; $display("FAIL addi_wb: state=%0d rf_we=%b wb_sel=%0d exp 4/1/0", state, rf_we, wb_sel);
    end
    cyc();
    tests++;
    if ({state, rf_we, imem_req, pc, imem_addr} !== {3'd0, 1'b0, 1'b1, 32'h104, 32'h104}) begin
      fails++; $display("FAIL addi_next: state=%0d rf_we=%b req=%b pc=%h exp 0/0/1/104", state, rf_we, imem_req, pc);
    end
  endtask

  task automatic test_branch();
    for (int t = 0; t < 2; t++) begin
      do_reset();
      br_taken = (t == 0);
      fetch(32'h00000463, 32'd8);
      cyc(); cyc();
      tests++;
      if ({state, imem_req, pc} !== {3'd0, 1'b1, (t == 0) ? 32'h108 : 32'h104}) begin
        fails++; $display("FAIL branch_%0d: state=%0d req=%b pc=%h", t, state, imem_req, pc);
      end
    end
    br_taken = 1'b0;
  endtask

  task automatic test_load();
    int reqc = 0, wec = 0, rfc = 0, rfcyc = 0;
    logic [1:0] wbs = 2'd3;
    do_reset();
    fetch(32'h00002083, 32'd0);
    for (int c = 2; c <= 8; c++) begin
      if (dmem_req) reqc++;
      if (dmem_req && dmem_we) wec++;
      if (rf_we) begin rfc++; rfcyc = c; wbs = wb_sel; end
      // acks while the request is low must be ignored
      dmem_ack = (c == 2) || (c == 3) || (dmem_req && reqc == 4);
      cyc();
    end
    dmem_ack = 1'b0;
    tests++;
    if (reqc != 4 || wec != 0) begin
      fails++; $display("FAIL load_req: req_cycles=%0d we_cycles=%0d exp 4/0", reqc, wec);
    end
    tests++;
    if (rfc != 1 || rfcyc != 8 || wbs !== 2'd1) begin
      fails++; $display("FAIL load_wb: rf_we_pulses=%0d at=%0d wb_sel=%0d exp 1/8/1", rfc, rfcyc, wbs);
    end
    tests++;
    if ({state, dmem_req, pc} !== {3'd0, 1'b0, 32'h104}) begin
      fails++; $display("FAIL load_next: state=%0d dreq=%b pc=%h exp 0/0/104", state, dmem_req, pc);
    end
  endtask

  task automatic test_store();
    do_reset();
    fetch(32'h00102023, 32'd0);
    cyc(); cyc();
    tests++;
    if ({state, dmem_req, dmem_we} !== {3'd3, 1'b1, 1'b1}) begin
      fails++; $display("FAIL store_mem: state=%0d dreq=%b we=%b exp 3/1/1", state, dmem_req, dmem_we);
    end
    dmem_ack = 1'b1;
    cyc();
    dmem_ack = 1'b0;
    tests++;
    if ({state, dmem_req, rf_we, pc} !== {3'd0, 1'b0, 1'b0, 32'h104}) begin
      fails++; $display("FAIL store_next: state=%0d dreq=%b rf_we=%b pc=%h exp 0/0/0/104", state, dmem_req, rf_we, pc);
    end
  endtask

  task automatic test_jal();
    do_reset();
    fetch(32'h008000EF, 32'd8);
    cyc(); cyc();
    tests++;
    if ({rf_we, wb_sel, link_pc} !== {1'b1, 2'd2, 32'h104}) begin
      fails++; $display("FAIL jal_wb: rf_we=%b wb_sel=%0d link=%h exp 1/2/104", rf_we, wb_sel, link_pc);
    end
    cyc();
    tests++;
    if ({state, pc} !== {3'd0, 32'h108}) begin
      fails++; $display("FAIL jal_pc: state=%0d pc=%h exp 0/108", state, pc);
    end
  endtask

  task automatic test_jalr_wrap();
    do_reset();
    alu_result = 32'hFFFF_FFFD;
    fetch(32'h000080E7, 32'd0);
    cyc(); cyc(); cyc();
    tests++;
    if ({state, pc, link_pc} !== {3'd0, 32'hFFFF_FFFC, 32'h0}) begin
      fails++; $display("FAIL jalr_target: state=%0d pc=%h link=%h exp 0/fffffffc/0", state, pc, link_pc);
    end
    fetch(32'h00500093, 32'd5);
    cyc(); cyc(); cyc();
    tests++;
    if ({state, pc} !== {3'd0, 32'h0}) begin
      fails++; $display("FAIL pc_wrap: state=%0d pc=%h exp 0/0", state, pc);
    end
  endtask

  task automatic test_illegal();
    int reqs = 0, rfs = 0;
    do_reset();
    fetch(32'h0000007F, 32'd0);
    cyc();
    tests++;
    if ({state, illegal} !== {3'd7, 1'b1}) begin
      fails++; $display("FAIL illegal_op: state=%0d illegal=%b exp 7/1", state, illegal);
    end
    imem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (imem_req) reqs++;
      if (rf_we) rfs++;
      cyc();
    end
    imem_ack = 1'b0;
    tests++;
    if (reqs != 0 || rfs != 0 || state !== 3'd7) begin
      fails++; $display("FAIL halt_absorb: reqs=%0d rf_we=%0d state=%0d exp 0/0/7", reqs, rfs, state);
    end
  endtask

  task automatic test_jalr_misaligned();
    int reqs = 0, rfs = 0;
    do_reset();
    alu_result = 32'h0000_0202;
    fetch(32'h000080E7, 32'd0);
    for (int c = 2; c <= 8; c++) begin
      if (rf_we) rfs++;
      if (c >= 5 && imem_req) reqs++;
      cyc();
    end
    tests++;
    if ({state, illegal, pc} !== {3'd7, 1'b1, 32'h100}) begin
      fails++; $display("FAIL jalr_misalign: state=%0d illegal=%b pc=%h exp 7/1/100", state, illegal, pc);
    end
    tests++;
    if (rfs != 0 || reqs != 0) begin
      fails++; $display("FAIL jalr_misalign_quiet: rf_we=%0d reqs=%0d exp 0/0", rfs, reqs);
    end
  endtask

  task automatic test_timeout();
`ifdef CORE_CTRL_TIMEOUT_EN
    int n = 0;
    do_reset();
    for (int i = 0; i < 400 && state != 3'd7; i++) begin
      if (imem_req) n++;
      cyc();
    end
    tests++;
    if (n != 255 || bus_err !== 1'b1 || state !== 3'd7) begin
      fails++; $display("FAIL timeout: waits=%0d bus_err=%b state=%0d exp 255/1/7", n, bus_err, state);
    end
    do_reset();
    repeat (254) cyc();
    imem_ack = 1'b1; imem_rdata = 32'h00500093;
    cyc();
    imem_ack = 1'b0;
    tests++;
    if ({state, bus_err} !== {3'd1, 1'b0}) begin
      fails++; $display("FAIL ack_wins: state=%0d bus_err=%b exp 1/0", state, bus_err);
    end
`else
    do_reset();
    repeat (300) cyc();
    tests++;
    if ({state, imem_req, bus_err} !== {3'd0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL no_timeout: state=%0d req=%b bus_err=%b exp 0/1/0", state, imem_req, bus_err);
    end
`endif
    repeat (100) cyc();
    rst_n = 1'b0;
    cyc();
    tests++;
    if ({imem_req, bus_err, state, pc} !== {1'b0, 1'b0, 3'd0, 32'h100}) begin
      fails++; $display("FAIL midwait_reset: req=%b bus_err=%b state=%0d pc=%h exp 0/0/0/100", imem_req, bus_err, state, pc);
    end
    rst_n = 1'b1;
    cyc();
    tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
      fails++; $display("FAIL midwait_refetch: req=%b addr=%h exp 1/100", imem_req, imem_addr);
    end
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; imm_val = '0;
    alu_result = '0; br_taken = 1'b0; dmem_ack = 1'b0;
    cyc();
    test_reset();
    test_addi();
    test_branch();
    test_load();
    test_store();
    test_jal();
    test_jalr_wrap();
    test_illegal();
    test_jalr_misaligned();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
